// File: rtl/fp_norm_pkg.sv
// rtl/fp_norm_pkg.sv - shared constants and helpers for the iterative mantissa normaliser
// Contents:
//   S_IDLE/S_SHIFT/S_DONE  FSM state encodings
//   EXP_MIN_NORM           smallest biased exponent of a normal number
//   sh_width()             width needed to hold a shift count of 0..mant_w
package fp_norm_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int EXP_MIN_NORM = 1;

  function automatic int sh_width(input int mant_w);
    return $clog2(mant_w + 1);
  endfunction

endpackage

// File: rtl/fp_norm_iter_lzc.sv
// rtl/fp_norm_iter_lzc.sv - combinational leading-zero counter
// Ports:
//   a    in   W   value to scan (MSB first)
//   cnt  out  OW  number of leading zeros; W when a is all zero
module lzc #(
  parameter int W  = 24,
  parameter int OW = 5
) (
  input  logic [W-1:0]  a,
  output logic [OW-1:0] cnt
);

  // Ascending scan: the last set bit found is the highest one.
  always_comb begin
    cnt = OW'(W);
    for (int i = 0; i < W; i++) begin
      if (a[i]) cnt = OW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_norm_iter.sv
// rtl/fp_norm_iter.sv - multi-cycle mantissa normaliser (up to STEP left shifts per cycle)
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        operand handshake (ready only while idle)
//   in_mant, in_exp          unnormalised mantissa and its biased exponent
//   out_valid/out_ready      result handshake (result held until accepted)
//   out_mant, out_exp        normalised mantissa and adjusted exponent
//   out_shift, out_adjust    total left shift applied, and whether it is nonzero
//   out_zero, out_underflow  zero input, stopped at the exponent floor (denormal)
module fp_norm_iter
  import fp_norm_pkg::*;
#(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 10,
  parameter int STEP   = 1,
  localparam int SH_W  = sh_width(MANT_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic [SH_W-1:0]   out_shift,
  output logic              out_adjust,
  output logic              out_zero,
  output logic              out_underflow
);

  // Wide enough to compare exponent headroom against shift counts without wrap.
  localparam int CW = ((EXP_W > SH_W) ? EXP_W : SH_W) + 1;

  logic [1:0]        state;
  logic [MANT_W-1:0] mant_r;
  logic [EXP_W-1:0]  exp_r;
  logic [SH_W-1:0]   shift_r;
  logic              zero_r;
  logic              uf_r;

  logic [SH_W-1:0]   lz;
  logic [CW-1:0]     room;
  logic [SH_W-1:0]   sh;
  logic [MANT_W-1:0] mant_next;
  logic [EXP_W-1:0]  exp_next;

  lzc #(.W(MANT_W), .OW(SH_W)) u_lzc (
    .a   (mant_r),
    .cnt (lz)
  );

  // Shift amount for this cycle: min(lz, STEP, exp_r - 1). Only meaningful in
  // SHIFT, where exp_r >= 2 and mant_r is nonzero with MSB clear, so sh >= 1.
  always_comb begin
    room = CW'(exp_r) - CW'(EXP_MIN_NORM);
    sh   = lz;
    if (CW'(STEP) < CW'(sh)) sh = SH_W'(STEP);
    if (room < CW'(sh))      sh = room[SH_W-1:0];
    mant_next = mant_r << sh;
    exp_next  = exp_r - EXP_W'(sh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mant_r  <= '0;
      exp_r   <= '0;
      shift_r <= '0;
      zero_r  <= 1'b0;
      uf_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mant_r  <= in_mant;
            exp_r   <= in_exp;
            shift_r <= '0;
            zero_r  <= 1'b0;
            uf_r    <= 1'b0;
            if (in_mant == '0) begin
              zero_r <= 1'b1;
              exp_r  <= '0;
              state  <= S_DONE;
            end else if (in_mant[MANT_W-1]) begin
              state <= S_DONE;
            end else if (in_exp <= EXP_W'(EXP_MIN_NORM)) begin
              uf_r  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          mant_r  <= mant_next;
          exp_r   <= exp_next;
          shift_r <= shift_r + sh;
          if (mant_next[MANT_W-1]) begin
            state <= S_DONE;
          end else if (exp_next == EXP_W'(EXP_MIN_NORM)) begin
            uf_r  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = (state == S_IDLE);
  assign out_valid     = (state == S_DONE);
  assign out_mant      = mant_r;
  assign out_exp       = exp_r;
  assign out_shift     = shift_r;
  assign out_adjust    = (shift_r != '0);
  assign out_zero      = zero_r;
  assign out_underflow = uf_r;

endmodule

// File: tb/tb_fp_norm_iter.sv
// tb/tb_fp_norm_iter.sv - directed self-checking bench for fp_norm_iter (STEP=1 and STEP=4 instances)
// No ports; instance 0 uses STEP=1, instance 1 uses STEP=4, sharing clk and rst_n.
module tb_fp_norm_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid [2];
  logic        in_ready [2];
  logic [23:0] in_mant [2];
  logic [9:0]  in_exp [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [23:0] out_mant [2];
  logic [9:0]  out_exp [2];
  logic [4:0]  out_shift [2];
  logic        out_adjust [2];
  logic        out_zero [2];
  logic        out_underflow [2];

  fp_norm_iter #(.MANT_W(24), .EXP_W(10), .STEP(1)) d1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_mant(in_mant[0]), .in_exp(in_exp[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_mant(out_mant[0]), .out_exp(out_exp[0]), .out_shift(out_shift[0]),
    .out_adjust(out_adjust[0]), .out_zero(out_zero[0]), .out_underflow(out_underflow[0])
  );

  fp_norm_iter #(.MANT_W(24), .EXP_W(10), .STEP(4)) d4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_mant(in_mant[1]), .in_exp(in_exp[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_mant(out_mant[1]), .out_exp(out_exp[1]), .out_shift(out_shift[1]),
    .out_adjust(out_adjust[1]), .out_zero(out_zero[1]), .out_underflow(out_underflow[1])
  );

  typedef struct {
    int          dut;
    logic [23:0] mant;
    logic [9:0]  exp;
    logic [23:0] x_mant;
    logic [9:0]  x_exp;
    int          x_shift;
    logic        x_adj;
    logic        x_zero;
    logic        x_uf;
    int          x_lat;
  } vec_t;

  vec_t vecs [12];
  int   pass_cnt = 0;
  int   total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Latency counts rising edges from the accepting edge (inclusive) until out_valid.
  task automatic run_vec(input int d, input logic [23:0] m, input logic [9:0] e, output int lat);
    @(negedge clk);
    in_valid[d] = 1'b1;
    in_mant[d]  = m;
    in_exp[d]   = e;
    lat = 99;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      #1;
      in_valid[d] = 1'b0;
      if (out_valid[d]) begin
        lat = n + 1;
        break;
      end
    end
  endtask

  task automatic pop(input int d, input string tag);
    @(negedge clk);
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[d] = 1'b0;
    check({tag, " valid_after_pop"}, 32'(out_valid[d]), 32'd0);
    check({tag, " ready_after_pop"}, 32'(in_ready[d]), 32'd1);
  endtask

  task automatic check_vec(input vec_t v, input int lat, input string tag);
    check({tag, " mant"}, 32'(out_mant[v.dut]), 32'(v.x_mant));
    check({tag, " exp"}, 32'(out_exp[v.dut]), 32'(v.x_exp));
    check({tag, " shift"}, 32'(out_shift[v.dut]), 32'(v.x_shift));
    check({tag, " adjust"}, 32'(out_adjust[v.dut]), 32'(v.x_adj));
    check({tag, " zero"}, 32'(out_zero[v.dut]), 32'(v.x_zero));
    check({tag, " underflow"}, 32'(out_underflow[v.dut]), 32'(v.x_uf));
    check({tag, " latency"}, 32'(lat), 32'(v.x_lat));
  endtask

  initial begin
    int lat;
    vec_t v;

    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0;
      in_mant[i] = '0;
      in_exp[i] = '0;
      out_ready[i] = 1'b0;
    end

    //            dut mant        exp   x_mant      x_exp  sh  adj  zero uf   lat
    vecs[0]  = '{0, 24'h800000, 10'd127, 24'h800000, 10'd127, 0,  1'b0, 1'b0, 1'b0, 1};
    vecs[1]  = '{0, 24'h400000, 10'd127, 24'h800000, 10'd126, 1,  1'b1, 1'b0, 1'b0, 2};
    vecs[2]  = '{1, 24'h000300, 10'd100, 24'hC00000, 10'd86,  14, 1'b1, 1'b0, 1'b0, 5};
    vecs[3]  = '{1, 24'h000010, 10'd5,   24'h000100, 10'd1,   4,  1'b1, 1'b0, 1'b1, 2};
    vecs[4]  = '{0, 24'h000000, 10'd77,  24'h000000, 10'd0,   0,  1'b0, 1'b1, 1'b0, 1};
    vecs[5]  = '{0, 24'h000001, 10'd0,   24'h000001, 10'd0,   0,  1'b0, 1'b0, 1'b1, 1};
    vecs[6]  = '{0, 24'h000007, 10'd3,   24'h00001C, 10'd1,   2,  1'b1, 1'b0, 1'b1, 3};
    vecs[7]  = '{1, 24'h000001, 10'd200, 24'h800000, 10'd177, 23, 1'b1, 1'b0, 1'b0, 7};
    vecs[8]  = '{0, 24'h200000, 10'd127, 24'h800000, 10'd125, 2,  1'b1, 1'b0, 1'b0, 3};
    vecs[9]  = '{1, 24'h7FFFFF, 10'd1,   24'h7FFFFF, 10'd1,   0,  1'b0, 1'b0, 1'b1, 1};
    vecs[10] = '{1, 24'h800001, 10'd0,   24'h800001, 10'd0,   0,  1'b0, 1'b0, 1'b0, 1};
    vecs[11] = '{1, 24'h0F0000, 10'd2,   24'h1E0000, 10'd1,   1,  1'b1, 1'b0, 1'b1, 2};

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset in_ready", 32'(in_ready[i]), 32'd1);
      check("reset out_valid", 32'(out_valid[i]), 32'd0);
      check("reset out_mant", 32'(out_mant[i]), 32'd0);
      check("reset out_shift", 32'(out_shift[i]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      run_vec(v.dut, v.mant, v.exp, lat);
      check_vec(v, lat, $sformatf("vec%0d", i));
      pop(v.dut, $sformatf("vec%0d", i));
    end

    // Backpressure: result must hold and new operands must be ignored.
    run_vec(0, 24'h400000, 10'd127, lat);
    check("bp latency", 32'(lat), 32'd2);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid[0] = 1'b1;
      in_mant[0]  = 24'h123456 + 24'(c);
      in_exp[0]   = 10'd9;
      @(posedge clk);
      #1;
      check("bp out_valid", 32'(out_valid[0]), 32'd1);
      check("bp in_ready", 32'(in_ready[0]), 32'd0);
      check("bp out_mant", 32'(out_mant[0]), 32'h800000);
      check("bp out_exp", 32'(out_exp[0]), 32'd126);
      check("bp out_shift", 32'(out_shift[0]), 32'd1);
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    pop(0, "bp");

    // Reset in the middle of a long shift sequence.
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_mant[0]  = 24'h000001;
    in_exp[0]   = 10'd200;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    check("mid in_ready busy", 32'(in_ready[0]), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst out_valid", 32'(out_valid[0]), 32'd0);
    check("rst in_ready", 32'(in_ready[0]), 32'd1);
    check("rst out_mant", 32'(out_mant[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    v = vecs[1];
    run_vec(v.dut, v.mant, v.exp, lat);
    check_vec(v, lat, "post_rst");
    pop(v.dut, "post_rst");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/fp_norm_iter.md
Name: fp_norm_iter

Overview:
- Multi-cycle, parametrised mantissa normaliser for the floating-point datapath, placed after the divider/multiplier mantissa stage and before rounding.
- Accepts an unnormalised mantissa plus biased exponent over a valid/ready handshake.
- Shifts left by up to STEP positions per cycle until the MSB is 1, decrementing the exponent by the same amount each cycle.
- Flags zero results, exponent underflow (denormal) and whether any adjustment was made.

Parameters:
MANT_W, 24, mantissa width including the hidden bit (MSB = hidden-bit position)
EXP_W, 10, biased exponent width (unsigned)
STEP, 1, maximum left shift per cycle; legal range 1..MANT_W

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input operand valid
in_ready  output  1  block can accept; equals (state==IDLE)
in_mant  input  MANT_W  unnormalised mantissa
in_exp  input  EXP_W  biased exponent of in_mant
out_valid  output  1  result valid; held until accepted
out_ready  input  1  downstream accepts result
out_mant  output  MANT_W  normalised mantissa
out_exp  output  EXP_W  adjusted exponent
out_shift  output  SH_W=$clog2(MANT_W+1)  total left shift applied
out_adjust  output  1  1 iff out_shift != 0
out_zero  output  1  input mantissa was zero
out_underflow  output  1  stopped at exp==1 with MSB still 0 (denormal)

Behaviour:
- Clock and reset: clk is the only clock; rst_n is asynchronous, active-low.
- Reset: state=IDLE, so in_ready=1; out_valid=0; all other outputs and internal registers are 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture in_mant/in_exp into mant_r/exp_r and clear shift_r.
  - Next state by priority:
    - in_mant==0 -> DONE with zero=1, exp_r=0.
    - in_mant[MSB]==1 -> DONE.
    - in_exp<=1 -> DONE with underflow=1 and no shift.
    - otherwise -> SHIFT.
- SHIFT (in_ready=0), once per cycle:
  - lz = leading-zero count of mant_r.
  - sh = min(lz, STEP, exp_r-1).
  - mant_r <<= sh (zero fill); exp_r -= sh; shift_r += sh.
  - If the post-shift MSB==1 -> DONE.
  - Else if the post-shift exp_r==1 -> DONE with underflow=1.
  - Else stay in SHIFT.
- DONE:
  - out_valid=1; out_* are driven from registers and held stable while out_ready=0.
  - On out_ready: return to IDLE (in_ready=1 from the next cycle). There is no same-cycle turnaround.
- Latency: 1 cycle from accept to DONE if no shift is needed; otherwise 1 + ceil(lz/STEP) cycles, reduced when the exponent floor limits the shift.
  - Example: STEP=1, lz=3 -> out_valid asserts 4 cycles after acceptance.
- Width rules:
  - The exponent never wraps below 1 for nonzero inputs.
  - out_shift never exceeds MANT_W-1.
  - The exponent is not incremented; overflow is the rounder's responsibility.
- Handshake:
  - in_valid is ignored outside IDLE.
  - out_valid deasserts only after the out_ready handshake or reset.
  - in_valid and out_ready may be asserted in any cycle; only the current state's signal matters.
- Reset mid-operation: immediately returns to IDLE, clears out_valid and discards the operand. No partial result is emitted.

Decomposition:
- fp_norm_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the function clog2-based SH_W helper;
  - a constant EXP_MIN_NORM=1.
- One sub-module: lzc (parametrised combinational leading-zero counter, width MANT_W, output SH_W, returns MANT_W for all-zero input).

Test Plan:
- MANT_W=24, STEP=1, in_mant=0x800000, in_exp=127 -> out_valid 1 cycle after accept; mant 0x800000, exp 127, shift 0, adjust 0.
- in_mant=0x400000, in_exp=127 -> 2 cycles; mant 0x800000, exp 126, shift 1, adjust 1 (matches the single-shift legacy case).
- STEP=4, in_mant=0x000300, in_exp=100 -> lz=14, 1+4 cycles; mant 0xC00000, exp 86, shift 14.
- in_mant=0x000010, in_exp=5 -> stops at exp 1; mant 0x000100 (shift 4), underflow 1.
- in_mant=0, in_exp=77 -> 1 cycle; zero=1, mant 0, exp 0, shift 0. Also in_exp=0 with mant 0x000001 -> no shift, underflow=1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored.
  - Assert rst_n=0 during SHIFT -> out_valid=0 and in_ready=1 immediately; the next operand is processed correctly.
